branch_target_buffer: RTL and testbench

//  Direct-mapped branch target buffer with one 2-bit hysteresis counter per entry.

---
 rtl/branch_target_buffer.sv | 179 +++++++++++++++++
 tb/tb_branch_target_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit hysteresis counter per entry.
// Fetch looks up its PC combinationally every cycle. Execute trains the table
// with each resolved control-flow instruction. Two saturating performance
// counters track lookup hits and reported mispredictions.

package branch_target_buffer_pkg;
    // PC source selection offered to the fetch-stage PC mux.
    typedef enum logic [0:0] {
        PCPLUS4 = 1'b0,
        PCJUMP  = 1'b1
    } pcsrc_t;

    // Hysteresis counter states. Bit 1 set means predict taken.
    typedef enum logic [1:0] {
        SNTAKEN = 2'd0,
        WNTAKEN = 2'd1,
        WTAKEN  = 2'd2,
        STAKEN  = 2'd3
    } bp_ctr_t;
endpackage

module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 20,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    // fetch-side lookup
    input  logic [63:0]      lookup_pc,
    output logic             hit,
    output logic [63:0]      pred_target,
    output pcsrc_t           bp_pcsrc,
    // execute-side training
    input  logic             upd_valid,
    input  logic [63:0]      upd_pc,
    input  logic [63:0]      upd_target,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    // performance counters
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_W + IDX_W + 1;

    // Table storage, one slot per index.
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [63:0]          target_q [ENTRIES];
    bp_ctr_t              ctr_q    [ENTRIES];

    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

    // Address split for both ports. pc[1:0] never takes part.
    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_W-1:0]     up_tag;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[TAG_HI:TAG_LO];

    // PC bits outside index/tag are deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[63:TAG_HI+1], lookup_pc[1:0],
                              upd_pc[63:TAG_HI+1], upd_pc[1:0]};

    // Lookup reads registered state only, so an update in this cycle is not
    // visible until the next one.
    always_comb begin
        hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_target = '0;
        bp_pcsrc    = PCPLUS4;
        if (hit) begin
            pred_target = target_q[lk_idx];
            if (ctr_q[lk_idx][1]) begin
                bp_pcsrc = PCJUMP;
            end
        end
    end

    // Training decision: what, if anything, gets written into the entry
    // selected by upd_pc.
    logic                 wr_en;
    logic                 wr_valid_d;
    logic [TAG_W-1:0]     wr_tag_d;
    logic [63:0]          wr_target_d;
    bp_ctr_t              wr_ctr_d;
    logic                 up_match;

    always_comb begin
        up_match    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        wr_en       = 1'b0;
        wr_valid_d  = 1'b1;
        wr_tag_d    = up_tag;
        wr_target_d = upd_target;
        wr_ctr_d    = ctr_q[up_idx];
        if (upd_valid && en) begin
            if (up_match) begin
                // Existing entry: refresh target and step the counter.
                wr_en = 1'b1;
                if (upd_taken) begin
                    unique case (ctr_q[up_idx])
                        SNTAKEN: wr_ctr_d = WNTAKEN;
                        WNTAKEN: wr_ctr_d = STAKEN;
                        WTAKEN:  wr_ctr_d = STAKEN;
                        STAKEN:  wr_ctr_d = STAKEN;
                        default: wr_ctr_d = WTAKEN;
                    endcase
                end else begin
                    unique case (ctr_q[up_idx])
                        SNTAKEN: wr_ctr_d = SNTAKEN;
                        WNTAKEN: wr_ctr_d = SNTAKEN;
                        WTAKEN:  wr_ctr_d = SNTAKEN;
                        STAKEN:  wr_ctr_d = WTAKEN;
                        default: wr_ctr_d = WTAKEN;
                    endcase
                end
            end else if (upd_taken) begin
                // Taken branch not in the table: allocate over whatever is there.
                wr_en    = 1'b1;
                wr_ctr_d = WTAKEN;
            end
        end
    end

    // Table update; reset clears every entry and drops any in-flight update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WTAKEN;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= wr_valid_d;
            tag_q[up_idx]    <= wr_tag_d;
            target_q[up_idx] <= wr_target_d;
            ctr_q[up_idx]    <= wr_ctr_d;
        end
    end

    // Saturating performance counter next values; they stick at all-ones.
    always_comb begin
        hit_cnt_d     = hit_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (en && hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (en && upd_valid && upd_mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            hit_cnt_q     <= hit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign hit_cnt     = hit_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer. A second instance with 3-bit
// performance counters shares all inputs so counter saturation is reachable.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        en;
  logic [63:0] lookup_pc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        hit;
  logic [63:0] pred_target;
  pcsrc_t      bp_pcsrc;
  logic [31:0] hit_cnt;
  logic [31:0] mispred_cnt;

  logic        s_hit;
  logic [63:0] s_pred_target;
  pcsrc_t      s_bp_pcsrc;
  logic [2:0]  s_hit_cnt;
  logic [2:0]  s_mispred_cnt;

  int checks = 0;
  int passed = 0;
  int exp_hit = 0;
  int exp_mis = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  branch_target_buffer #(.ENTRIES(64), .TAG_W(20), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en),
    .lookup_pc(lookup_pc), .hit(hit), .pred_target(pred_target), .bp_pcsrc(bp_pcsrc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_target_buffer #(.ENTRIES(64), .TAG_W(20), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .en(en),
    .lookup_pc(lookup_pc), .hit(s_hit), .pred_target(s_pred_target), .bp_pcsrc(s_bp_pcsrc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .hit_cnt(s_hit_cnt), .mispred_cnt(s_mispred_cnt)
  );

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt,
                           input logic taken, input logic mis);
    upd_pc = pc;
    upd_target = tgt;
    upd_taken = taken;
    upd_mispredict = mis;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    if (mis) exp_mis++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;
    upd_mispredict = 1'b0;
    lookup_pc = 64'h8000_0000;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++; if (hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", hit); else passed++;
    checks++; if (pred_target !== 64'h0) $display("FAIL reset_target: got %h want 0", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL reset_pcsrc: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    checks++; if (hit_cnt !== 32'd0) $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); else passed++;
    checks++; if (mispred_cnt !== 32'd0) $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); else passed++;
    lookup_pc = 64'h0;
  endtask

  task automatic test_allocate();
    do_update(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0);
    lookup_pc = 64'h8000_0010;
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL alloc_hit: got %0b want 1", hit); else passed++;
    checks++; if (pred_target !== 64'h8000_0100) $display("FAIL alloc_target: got %h want 80000100", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL alloc_pcsrc: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    // Low two PC bits are not part of the match.
    lookup_pc = 64'h8000_0013;
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL low_bits_ignored: got %0b want 1", hit); else passed++;
    lookup_pc = 64'h0;
  endtask

  task automatic test_hysteresis();
    // WT -nt-> SN, target refreshed even on not-taken
    do_update(64'h8000_0010, 64'h8000_0200, 1'b0, 1'b1);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL hyst_wt_nt: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    checks++; if (pred_target !== 64'h8000_0200) $display("FAIL hyst_target_refresh: got %h want 80000200", pred_target); else passed++;
    lookup_pc = 64'h0;
    // SN -nt-> SN
    do_update(64'h8000_0010, 64'h8000_0200, 1'b0, 1'b0);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL hyst_sn_nt: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    lookup_pc = 64'h0;
    // SN -t-> WN (still not taken)
    do_update(64'h8000_0010, 64'h8000_0200, 1'b1, 1'b0);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL hyst_sn_t: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    lookup_pc = 64'h0;
    // WN -t-> ST
    do_update(64'h8000_0010, 64'h8000_0200, 1'b1, 1'b0);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL hyst_wn_t: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    lookup_pc = 64'h0;
    // ST -nt-> WT (still taken)
    do_update(64'h8000_0010, 64'h8000_0200, 1'b0, 1'b0);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL hyst_st_nt: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    lookup_pc = 64'h0;
    // WT -nt-> SN
    do_update(64'h8000_0010, 64'h8000_0200, 1'b0, 1'b0);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL hyst_wt_nt2: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    lookup_pc = 64'h0;
  endtask

  task automatic test_alias();
    // Same index (+4*ENTRIES), different tag: taken miss overwrites the slot.
    do_update(64'h8000_0110, 64'h9000_0000, 1'b1, 1'b1);
    lookup_pc = 64'h8000_0010; #1;
    checks++; if (hit !== 1'b0) $display("FAIL alias_orig_hit: got %0b want 0", hit); else passed++;
    checks++; if (pred_target !== 64'h0) $display("FAIL alias_orig_target: got %h want 0", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL alias_orig_pcsrc: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    lookup_pc = 64'h8000_0110; #1;
    checks++; if (hit !== 1'b1) $display("FAIL alias_hit: got %0b want 1", hit); else passed++;
    checks++; if (pred_target !== 64'h9000_0000) $display("FAIL alias_target: got %h want 90000000", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL alias_pcsrc: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    lookup_pc = 64'h0;
    // Not-taken miss must neither allocate nor disturb the resident entry.
    do_update(64'h8000_0210, 64'hA000_0000, 1'b0, 1'b1);
    lookup_pc = 64'h8000_0210; #1;
    checks++; if (hit !== 1'b0) $display("FAIL nt_miss_no_alloc: got %0b want 0", hit); else passed++;
    lookup_pc = 64'h8000_0110; #1;
    checks++; if (pred_target !== 64'h9000_0000) $display("FAIL nt_miss_keeps_target: got %h want 90000000", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL nt_miss_keeps_ctr: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    lookup_pc = 64'h0;
  endtask

  task automatic test_stall();
    // en=0: update with mispredict is dropped, held hit is not counted.
    en = 1'b0;
    upd_pc = 64'h8000_0110;
    upd_target = 64'hDEAD_0000;
    upd_taken = 1'b0;
    upd_mispredict = 1'b1;
    upd_valid = 1'b1;
    lookup_pc = 64'h8000_0110;
    #1;
    checks++; if (pred_target !== 64'h9000_0000) $display("FAIL stall_same_cycle: got %h want 90000000", pred_target); else passed++;
    tick();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL stall_lookup_tracks: got %0b want 1", hit); else passed++;
    en = 1'b1;
    checks++; if (pred_target !== 64'h9000_0000) $display("FAIL stall_target_kept: got %h want 90000000", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL stall_ctr_kept: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    checks++; if (mispred_cnt !== 32'(exp_mis)) $display("FAIL stall_mispred_cnt: got %0d want %0d", mispred_cnt, exp_mis); else passed++;
    checks++; if (hit_cnt !== 32'(exp_hit)) $display("FAIL stall_hit_cnt: got %0d want %0d", hit_cnt, exp_hit); else passed++;
    lookup_pc = 64'h0;
  endtask

  task automatic test_back_to_back();
    // Update and lookup of the same entry in one cycle: lookup sees old data.
    upd_pc = 64'h8000_0110;
    upd_target = 64'hB000_0000;
    upd_taken = 1'b0;
    upd_mispredict = 1'b0;
    upd_valid = 1'b1;
    lookup_pc = 64'h8000_0110;
    #1;
    checks++; if (pred_target !== 64'h9000_0000) $display("FAIL b2b_old_target: got %h want 90000000", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCJUMP) $display("FAIL b2b_old_pcsrc: got %0d want %0d", bp_pcsrc, PCJUMP); else passed++;
    tick();
    exp_hit++;
    upd_valid = 1'b0;
    checks++; if (pred_target !== 64'hB000_0000) $display("FAIL b2b_new_target: got %h want b0000000", pred_target); else passed++;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL b2b_new_pcsrc: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    lookup_pc = 64'h0;
    #1;
    checks++; if (hit_cnt !== 32'(exp_hit)) $display("FAIL b2b_hit_cnt: got %0d want %0d", hit_cnt, exp_hit); else passed++;
  endtask

  task automatic test_counters();
    logic [2:0] exp_s;
    // Hold a hitting PC for nine enabled edges.
    lookup_pc = 64'h8000_0110;
    repeat (9) begin
      tick();
      exp_hit++;
    end
    lookup_pc = 64'h0;
    #1;
    exp_s = (exp_hit > 7) ? 3'd7 : 3'(exp_hit);
    checks++; if (hit_cnt !== 32'(exp_hit)) $display("FAIL hit_cnt_count: got %0d want %0d", hit_cnt, exp_hit); else passed++;
    checks++; if (s_hit_cnt !== exp_s) $display("FAIL hit_cnt_saturate: got %0d want %0d", s_hit_cnt, exp_s); else passed++;
    // One more hit on a saturated counter stays all-ones.
    lookup_pc = 64'h8000_0110;
    tick();
    exp_hit++;
    lookup_pc = 64'h0;
    checks++; if (s_hit_cnt !== 3'd7) $display("FAIL hit_cnt_stays_ones: got %0d want 7", s_hit_cnt); else passed++;
    // Mispredicts on an unallocated index: no table change, counter moves.
    for (int i = 0; i < 6; i++) do_update(64'h0, 64'h0, 1'b0, 1'b1);
    exp_s = (exp_mis > 7) ? 3'd7 : 3'(exp_mis);
    checks++; if (mispred_cnt !== 32'(exp_mis)) $display("FAIL mispred_count: got %0d want %0d", mispred_cnt, exp_mis); else passed++;
    checks++; if (s_mispred_cnt !== exp_s) $display("FAIL mispred_saturate: got %0d want %0d", s_mispred_cnt, exp_s); else passed++;
    lookup_pc = 64'h0; #1;
    checks++; if (hit !== 1'b0) $display("FAIL nt_mispred_no_alloc: got %0b want 0", hit); else passed++;
  endtask

  task automatic test_reset_mid_update();
    upd_pc = 64'h8000_0020;
    upd_target = 64'hC000_0000;
    upd_taken = 1'b1;
    upd_mispredict = 1'b1;
    upd_valid = 1'b1;
    reset = 1'b1;
    tick();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    reset = 1'b0;
    exp_hit = 0;
    exp_mis = 0;
    lookup_pc = 64'h8000_0020; #1;
    checks++; if (hit !== 1'b0) $display("FAIL rst_mid_upd_lost: got %0b want 0", hit); else passed++;
    lookup_pc = 64'h8000_0110; #1;
    checks++; if (hit !== 1'b0) $display("FAIL rst_mid_cleared: got %0b want 0", hit); else passed++;
    checks++; if (bp_pcsrc !== PCPLUS4) $display("FAIL rst_mid_pcsrc: got %0d want %0d", bp_pcsrc, PCPLUS4); else passed++;
    checks++; if (hit_cnt !== 32'd0) $display("FAIL rst_mid_hit_cnt: got %0d want 0", hit_cnt); else passed++;
    checks++; if (mispred_cnt !== 32'd0) $display("FAIL rst_mid_mispred_cnt: got %0d want 0", mispred_cnt); else passed++;
    checks++; if (s_hit_cnt !== 3'd0) $display("FAIL rst_mid_sat_hit_cnt: got %0d want 0", s_hit_cnt); else passed++;
    lookup_pc = 64'h0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_stall();
    test_back_to_back();
    test_counters();
    test_reset_mid_update();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
